// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and framing constants
//
// Purpose: definitions common to the UART receiver and transmitter.
//   uart_rx_state_t : receiver frame-tracking states
//   UART_DATA_BITS  : default number of data bits per frame
//   UART_START_BIT  : line level of the start bit
//   UART_STOP_BIT   : line level of the stop bit (also the idle level)
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - byte output handshake of the UART receiver
//
// Purpose: valid/ready byte channel from the receiver to its consumer.
// Signals:
//   data  : received byte, stable while valid
//   valid : byte available
//   ready : consumer takes the byte when valid && ready
// Modports:
//   master : byte producer (the receiver)
//   slave  : byte consumer
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an asynchronous input
//
// Purpose: brings an asynchronous level into the CLKIN domain.
// Ports:
//   CLKIN  : system clock, rising edge
//   RESETN : asynchronous active-low reset, both flops load RESET_VALUE
//   d      : asynchronous input
//   q      : synchronized output, two CLKIN edges behind d
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic CLKIN,
  input  logic RESETN,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with valid/ready byte output
//
// Purpose: recovers frames (start low, DATA_BITS data LSB first, stop high)
// from the asynchronous rx line and offers each byte on a valid/ready port.
// Bit timing comes from clock_enable, which ticks OVERSAMPLE times per bit.
// Ports:
//   CLKIN         : system clock, rising edge
//   RESETN        : asynchronous active-low reset
//   clock_enable  : sample tick, one CLKIN cycle wide
//   rx            : asynchronous serial input, idle high
//   out_if        : byte output (data / valid / ready), master side
//   framing_error : one-cycle pulse, stop bit sampled low
//   overrun       : one-cycle pulse, byte completed while holding reg full
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = 4
) (
  input  logic            CLKIN,
  input  logic            RESETN,
  input  logic            clock_enable,
  input  logic            rx,
  uart_receiver_if.master out_if,
  output logic            framing_error,
  output logic            overrun
);

  localparam int CW = $clog2(OVERSAMPLE + 1);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rxs;
  uart_rx_state_t       state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] sh;

  logic in_frame;
  logic sample_now;
  logic deliver;
  logic accept;

  uart_sync2 #(
    .RESET_VALUE (1'b1)
  ) u_sync (
    .CLKIN  (CLKIN),
    .RESETN (RESETN),
    .d      (rx),
    .q      (rxs)
  );

  assign in_frame   = (state == START) || (state == DATA) || (state == STOP);
  // cnt reaching 1 on a tick marks the centre of the current bit.
  assign sample_now = clock_enable && in_frame && (cnt == CNT_ONE);
  assign deliver    = sample_now && (state == STOP) && (rxs == UART_STOP_BIT);
  assign accept     = out_if.valid && out_if.ready;

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      sh            <= '0;
      out_if.data   <= '0;
      out_if.valid  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;

      // Holding register. A byte arriving in the same cycle as a handshake
      // replaces the one being taken, so a consumer with ready tied high
      // never loses bytes on back-to-back frames.
      if (deliver) begin
        if (!out_if.valid || out_if.ready) begin
          out_if.data  <= sh;
          out_if.valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        out_if.valid <= 1'b0;
      end

      if (clock_enable) begin
        case (state)
          IDLE: begin
            if (rxs == UART_START_BIT) begin
              state <= START;
              cnt   <= CNT_HALF;
            end
          end

          START, DATA, STOP: begin
            if (cnt != CNT_ONE) begin
              cnt <= cnt - CNT_ONE;
            end else begin
              cnt <= CNT_FULL;
              case (state)
                START: begin
                  // A high sample at the start-bit centre means the falling
                  // edge was only a glitch.
                  if (rxs == UART_START_BIT) begin
                    state <= DATA;
                    idx   <= '0;
                  end else begin
                    state <= IDLE;
                  end
                end
                DATA: begin
                  sh  <= {rxs, sh[DATA_BITS-1:1]};
                  idx <= idx + IDX_ONE;
                  if (idx == IDX_LAST) begin
                    state <= STOP;
                  end
                end
                default: begin
                  if (rxs == UART_STOP_BIT) begin
                    state <= IDLE;
                  end else begin
                    framing_error <= 1'b1;
                    sh            <= '0;
                    state         <= BREAK;
                  end
                end
              endcase
            end
          end

          // Wait for the line to return high so a held-low line is not
          // taken as a stream of start bits.
          BREAK: begin
            if (rxs == UART_STOP_BIT) begin
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int DB = 8;
  localparam int OS = 4;
  // 2 synchronizer edges + detection on the next tick, then the sample span.
  localparam int LATENCY = 3 + OS / 2 + (DB + 1) * OS;

  logic CLKIN        = 1'b0;
  logic RESETN       = 1'b0;
  logic clock_enable = 1'b1;
  logic rx           = 1'b1;
  logic ce_slow      = 1'b0;
  logic framing_error;
  logic overrun;

  uart_receiver_if #(.DATA_BITS(DB)) rx_if ();

  uart_receiver #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS)
  ) dut (
    .CLKIN         (CLKIN),
    .RESETN        (RESETN),
    .clock_enable  (clock_enable),
    .rx            (rx),
    .out_if        (rx_if.master),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 CLKIN = ~CLKIN;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fe_cycles = 0, ov_cycles = 0, valid_rises = 0, valid_cycles = 0, hs_cnt = 0;
  int start_cyc = 0, rise_cyc = 0;
  int r0 = 0, vc0 = 0, fe0 = 0, ov0 = 0, hs0 = 0;
  logic       valid_q = 1'b0;
  logic [1:0] tx_div  = 2'd0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLKIN) begin
    cyc    = cyc + 1;
    tx_div = tx_div + 2'd1;
  end

  always @(negedge CLKIN) clock_enable = ce_slow ? ~clock_enable : 1'b1;

  // Output monitor / scoreboard consumer.
  always @(negedge CLKIN) begin
    if (!RESETN) begin
      valid_q = 1'b0;
    end else begin
      if (rx_if.valid && !valid_q) begin
        valid_rises++;
        rise_cyc = cyc;
      end
      if (rx_if.valid)   valid_cycles++;
      if (framing_error) fe_cycles++;
      if (overrun)       ov_cycles++;
      check("fe_ov_exclusive", {31'd0, framing_error & overrun}, 32'd0);
      if (rx_if.valid && rx_if.ready) begin
        hs_cnt++;
        check("hs_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("hs_data", {24'd0, rx_if.data}, {24'd0, exp_q.pop_front()});
      end
      valid_q = rx_if.valid;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLKIN);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    step(n);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_b, input int bl);
    start_cyc = cyc;
    drive_bit(UART_START_BIT, bl);
    for (int i = 0; i < DB; i++) drive_bit(d[i], bl);
    drive_bit(stop_b, bl);
    rx = UART_STOP_BIT;
  endtask

  // Behavioural transmitter: one bit per tick of its own enable (every 4th cycle).
  task automatic tx_send(input logic [7:0] d);
    logic [9:0] fr;
    fr = {UART_STOP_BIT, d, UART_START_BIT};
    do step(1); while (tx_div != 2'd0);
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      do step(1); while (tx_div != 2'd0);
    end
  endtask

  task automatic snap();
    r0  = valid_rises;
    vc0 = valid_cycles;
    fe0 = fe_cycles;
    ov0 = ov_cycles;
    hs0 = hs_cnt;
  endtask

  initial begin
    rx_if.ready = 1'b0;
    step(3);
    check("rst_data", {24'd0, rx_if.data}, 32'd0);
    check("rst_valid", {31'd0, rx_if.valid}, 32'd0);
    check("rst_fe", {31'd0, framing_error}, 32'd0);
    check("rst_ov", {31'd0, overrun}, 32'd0);
    RESETN = 1'b1;
    step(4);

    // Single frame, ready held high.
    rx_if.ready = 1'b1;
    snap();
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, OS);
    step(6);
    check("a5_latency", rise_cyc - start_cyc, LATENCY);
    check("a5_valid_cycles", valid_cycles - vc0, 1);
    check("a5_fe", fe_cycles - fe0, 0);
    check("a5_ov", ov_cycles - ov0, 0);
    check("a5_consumed", exp_q.size(), 0);

    // Back-to-back frames with the consumer stalled.
    rx_if.ready = 1'b0;
    snap();
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1, OS);
    send(8'hC3, 1'b1, OS);
    step(6);
    check("ovr_pulses", ov_cycles - ov0, 1);
    check("ovr_valid", {31'd0, rx_if.valid}, 32'd1);
    check("ovr_data", {24'd0, rx_if.data}, 32'h3C);
    check("ovr_no_hs", hs_cnt - hs0, 0);
    check("ovr_fe", fe_cycles - fe0, 0);
    rx_if.ready = 1'b1;
    step(2);
    check("ovr_valid_drop", {31'd0, rx_if.valid}, 32'd0);
    check("ovr_one_hs", hs_cnt - hs0, 1);
    check("ovr_consumed", exp_q.size(), 0);

    // Short low glitch.
    snap();
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 12);
    check("glitch_rises", valid_rises - r0, 0);
    check("glitch_fe", fe_cycles - fe0, 0);
    check("glitch_ov", ov_cycles - ov0, 0);
    check("glitch_valid", {31'd0, rx_if.valid}, 32'd0);

    // Stop bit low, line held low, then a good frame.
    snap();
    send(8'h55, 1'b0, OS);
    drive_bit(1'b0, 30);
    check("brk_fe", fe_cycles - fe0, 1);
    check("brk_rises", valid_rises - r0, 0);
    drive_bit(1'b1, 8);
    exp_q.push_back(8'h0F);
    send(8'h0F, 1'b1, OS);
    step(6);
    check("brk_fe_after", fe_cycles - fe0, 1);
    check("brk_rises_after", valid_rises - r0, 1);
    check("brk_consumed", exp_q.size(), 0);
    check("brk_ov", ov_cycles - ov0, 0);

    // Reset in the middle of a frame while a byte is held.
    rx_if.ready = 1'b0;
    send(8'h66, 1'b1, OS);
    step(4);
    check("pre_rst_valid", {31'd0, rx_if.valid}, 32'd1);
    check("pre_rst_data", {24'd0, rx_if.data}, 32'h66);
    drive_bit(UART_START_BIT, OS);
    drive_bit(1'b1, 3 * OS);
    RESETN = 1'b0;
    #1;
    check("midrst_data", {24'd0, rx_if.data}, 32'd0);
    check("midrst_valid", {31'd0, rx_if.valid}, 32'd0);
    check("midrst_fe", {31'd0, framing_error}, 32'd0);
    check("midrst_ov", {31'd0, overrun}, 32'd0);
    step(2);
    rx = 1'b1;
    RESETN = 1'b1;
    step(4);
    rx_if.ready = 1'b1;
    snap();
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1, OS);
    step(6);
    check("postrst_rises", valid_rises - r0, 1);
    check("postrst_consumed", exp_q.size(), 0);
    check("postrst_fe", fe_cycles - fe0, 0);
    check("postrst_ov", ov_cycles - ov0, 0);

    // Loopback from a transmitter ticking every 4th cycle.
    snap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h5A);
    tx_send(8'h00);
    tx_send(8'hFF);
    tx_send(8'h5A);
    rx = 1'b1;
    step(8);
    check("lb_rises", valid_rises - r0, 3);
    check("lb_valid_cycles", valid_cycles - vc0, 3);
    check("lb_consumed", exp_q.size(), 0);
    check("lb_fe", fe_cycles - fe0, 0);
    check("lb_ov", ov_cycles - ov0, 0);

    // Sample tick every other cycle, bit period of 8 cycles.
    ce_slow = 1'b1;
    step(2);
    snap();
    exp_q.push_back(8'h96);
    send(8'h96, 1'b1, 2 * OS);
    step(12);
    check("slow_rises", valid_rises - r0, 1);
    check("slow_consumed", exp_q.size(), 0);
    check("slow_fe", fe_cycles - fe0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive half of the UART pair: recovers 8N1 frames (idle high, one low start bit, DATA_BITS data bits LSB first, one high stop bit) from an asynchronous `rx` line and presents each byte on a valid/ready output port. Bit timing is derived from `clock_enable`, which ticks OVERSAMPLE times per bit period. The block sits between the board RX pin and the byte consumer, and is the counterpart of the existing UART transmitter.

## Interface
- `DATA_BITS`, 8, data bits per frame.
- `OVERSAMPLE`, 4, `clock_enable` ticks per bit; even, ≥ 2.
- `CLKIN`  in  1  single system clock, rising edge.
- `RESETN`  in  1  reset, asynchronous, active-low.
- `clock_enable`  in  1  sample tick, one `CLKIN` cycle wide.
- `rx`  in  1  asynchronous serial input, idle high.
- `data`  out  DATA_BITS  received byte; stable while `valid`.
- `valid`  out  1  byte available.
- `ready`  in  1  consumer accepts the byte when `valid && ready`.
- `framing_error`  out  1  one-`CLKIN` pulse: stop bit sampled low.
- `overrun`  out  1  one-`CLKIN` pulse: a byte completed while the holding register was full; that byte is dropped.

## Operation
- `rx` passes through a 2-flop synchronizer clocked every `CLKIN` and reset to 1. All logic below uses the synchronized value `rxs`.
- Per-bit down-counter `cnt` (width clog2(OVERSAMPLE+1)) and bit index `idx`. Both advance only on `clock_enable` ticks.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on a tick with `rxs==0`, go to START and set `cnt<=OVERSAMPLE/2`.
- In START, DATA and STOP, on each tick: if `cnt!=1`, decrement `cnt`. Otherwise sample `rxs`, set `cnt<=OVERSAMPLE`, and act per state:
  - START: sample 0 goes to DATA with `idx<=0`. Sample 1 is a glitch and goes to IDLE with no output.
  - DATA: shift the sample into the MSB of shift register `sh` (right shift), then `idx<=idx+1`. After the DATA_BITS-th sample, go to STOP.
  - STOP, sample 1: deliver `sh` and go to IDLE.
  - STOP, sample 0: pulse `framing_error`, discard `sh`, and go to BREAK.
- BREAK: on a tick with `rxs==1`, go to IDLE. This prevents a held-low line from being re-detected as a start bit.
- Deliver:
  - If `valid==0`, or `valid && ready` in the same cycle: `data<=sh`, `valid<=1`.
  - Otherwise pulse `overrun`. `data` and `valid` stay unchanged and the new byte is lost.
- Handshake: when `valid && ready` and no delivery occurs in that cycle, `valid<=0`. `data` holds its last value.
- Reset (asynchronous, any state, including mid-frame): state IDLE, `cnt=0`, `idx=0`, `sh=0`, `data=0`, `valid=0`, `framing_error=0`, `overrun=0`, synchronizer flops = 1. No partial byte survives reset.

## Timing
- The start edge on `rx` is visible in `rxs` 2 `CLKIN` edges later. Detection happens on the first tick after that.
- Samples land at detection tick + OVERSAMPLE/2 (start-bit centre), then every OVERSAMPLE ticks: DATA_BITS data samples, then the stop sample.
- `valid` rises on the `CLKIN` edge of the stop-sample tick, so it is visible in the next cycle.
- From detection tick to `valid`: OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks.
- A new start can be detected on the tick after the stop sample, which gives back-to-back frames with no idle gap.
- `ready` may be held high permanently. With no stalls the consumer sees one `valid` cycle per byte.
- `framing_error` and `overrun` are each exactly one `CLKIN` cycle wide and can never both be high in the same cycle.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_t` enum (IDLE, START, DATA, STOP, BREAK).
  - Default `UART_DATA_BITS`.
  - Framing constants `UART_START_BIT=0` and `UART_STOP_BIT=1`, shared with the transmitter.
- Sub-module `uart_sync2`: 2-flop synchronizer with an asynchronous active-low reset value parameter.

## Test plan
- With OVERSAMPLE=4 and a tick every cycle, send frame 0xA5, `ready=1`: `data=0xA5`, `valid` high for 1 cycle, no error pulses.
- Send 0x3C then 0xC3 back-to-back with `ready=0` throughout: 0x3C is held, `overrun` pulses once at 0xC3's stop sample, `data` stays 0x3C. Then `ready=1` → one handshake and `valid` drops.
- Low glitch on `rx` shorter than OVERSAMPLE/2 ticks: returns to IDLE, no `valid`, no errors.
- Frame 0x55 with the stop bit low, then `rx` held low for 30 ticks: one `framing_error` pulse, no `valid`, stays in BREAK. After `rx` goes high, frame 0x0F is received correctly.
- Assert `RESETN=0` mid-DATA of frame 0xFF: all outputs go to 0 immediately. After release, the next full frame 0x81 is received correctly with no residue.
- Loopback from the transmitter, with its `clock_enable` every 4th cycle and this block's every cycle, bytes 0x00, 0xFF, 0x5A: all three received in order with no errors.
